// File: rtl/conv_sched_pkg.sv
// Shared types and default sizing for the conv row scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package conv_sched_pkg;

    localparam int KX_DEF  = 3;
    localparam int PIX_DEF = 3;
    localparam int RES_DEF = 8;
    localparam int CW_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        REQ_ROW,
        RUN,
        CAPTURE,
        EMIT,
        FIN
    } sched_state_t;

endpackage

// File: rtl/conv_row_scheduler_counter.sv
// Clearable up-counter used for the row and output-channel indices.
// Latency: count updates on the clock edge after clr/inc.
// Backpressure: none; clr has priority over inc, and the owner never asks it to wrap.
module GenericCounter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Clear wins over increment so a job start always begins from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_inc) begin
            r_q <= r_q + W'(1);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/conv_row_scheduler.sv
// Sequences weight loads and pixel rows into a conv engine, channel-outer / row-inner.
// Latency: result registered the cycle after eng_kernel_done, offered on out_valid the cycle after.
// Backpressure: EMIT holds out_* stable until out_ready; no new row/weight request meanwhile.
module conv_row_scheduler
    import conv_sched_pkg::*;
#(
    parameter int KX  = KX_DEF,
    parameter int PIX = PIX_DEF,
    parameter int RES = RES_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CW-1:0]      cfg_rows,
    input  logic [CW-1:0]      cfg_och,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               wt_req,
    output logic [CW-1:0]      wt_och,
    input  logic               wt_valid,
    output logic               row_req,
    output logic [CW-1:0]      row_idx,
    input  logic               row_valid,
    output logic               eng_pixel_ready,
    output logic               eng_weight_ready,
    input  logic               eng_kernel_done,
    input  logic [PIX*RES-1:0] eng_acc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIX*RES-1:0] out_data,
    output logic [CW-1:0]      out_row,
    output logic [CW-1:0]      out_och
);

    // The kernel width only shapes the engine's own timing; reject nonsense at elaboration.
    generate
        if (KX < 1) begin : g_kx_check
            $error("conv_row_scheduler: KX must be at least 1");
        end
    endgenerate

    sched_state_t        r_state;
    sched_state_t        w_next;

    logic [CW-1:0]       r_cfg_rows;
    logic [CW-1:0]       r_cfg_och;
    logic [CW-1:0]       w_row_cnt;
    logic [CW-1:0]       w_och_cnt;
    logic                w_row_clr;
    logic                w_row_inc;
    logic                w_och_clr;
    logic                w_och_inc;
    logic                w_last_row;
    logic                w_last_och;
    logic                w_emit_hs;

    logic                r_wt_rdy;
    logic                r_done;
    logic                r_err;
    logic [PIX*RES-1:0]  r_out_data;
    logic [CW-1:0]       r_out_row;
    logic [CW-1:0]       r_out_och;

    GenericCounter #(.W(CW)) u_row_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_row_clr),
        .i_inc (w_row_inc),
        .o_q   (w_row_cnt)
    );

    GenericCounter #(.W(CW)) u_och_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_och_clr),
        .i_inc (w_och_inc),
        .o_q   (w_och_cnt)
    );

    // Latched cfg is never zero once we leave IDLE for LOAD_W, so "minus one" cannot underflow.
    assign w_last_row = (w_row_cnt == (r_cfg_rows - CW'(1)));
    assign w_last_och = (w_och_cnt == (r_cfg_och - CW'(1)));
    assign w_emit_hs  = (r_state == EMIT) && out_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and counter control; the last channel does not bump och so nothing wraps.
    always_comb begin
        w_next    = r_state;
        w_row_clr = 1'b0;
        w_row_inc = 1'b0;
        w_och_clr = 1'b0;
        w_och_inc = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_row_clr = 1'b1;
                    w_och_clr = 1'b1;
                    if ((cfg_rows == '0) || (cfg_och == '0)) begin
                        w_next = FIN;
                    end else begin
                        w_next = LOAD_W;
                    end
                end
            end
            LOAD_W: begin
                if (wt_valid) begin
                    w_next = REQ_ROW;
                end
            end
            REQ_ROW: begin
                if (row_valid) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (eng_kernel_done) begin
                    w_next = CAPTURE;
                end
            end
            CAPTURE: begin
                w_next = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
                    if (!w_last_row) begin
                        w_row_inc = 1'b1;
                        w_next    = REQ_ROW;
                    end else begin
                        w_row_clr = 1'b1;
                        if (w_last_och) begin
                            w_next = FIN;
                        end else begin
                            w_och_inc = 1'b1;
                            w_next    = LOAD_W;
                        end
                    end
                end
            end
            FIN: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Job geometry is captured once so cfg changes during a job are invisible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_rows <= '0;
            r_cfg_och  <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_cfg_rows <= cfg_rows;
            r_cfg_och  <= cfg_och;
        end
    end

    // Weight-ready spans the whole channel: set on weight arrival, dropped on last-row handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wt_rdy <= 1'b0;
        end else if ((r_state == LOAD_W) && wt_valid) begin
            r_wt_rdy <= 1'b1;
        end else if (w_emit_hs && w_last_row) begin
            r_wt_rdy <= 1'b0;
        end
    end

    // Done is the registered image of FIN, so it appears alongside busy=0 back in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == FIN);
        end
    end

    // A kernel-done outside RUN is a protocol violation; flag it stickily, keep sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (eng_kernel_done && (r_state != RUN)) begin
            r_err <= 1'b1;
        end
    end

    // Single output stage: accumulators are sampled in CAPTURE, one cycle after kernel done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
            r_out_row  <= '0;
            r_out_och  <= '0;
        end else if (r_state == CAPTURE) begin
            r_out_data <= eng_acc;
            r_out_row  <= w_row_cnt;
            r_out_och  <= w_och_cnt;
        end
    end

    assign busy             = (r_state != IDLE);
    assign done             = r_done;
    assign err              = r_err;
    assign wt_req           = (r_state == LOAD_W);
    assign wt_och           = w_och_cnt;
    assign row_req          = (r_state == REQ_ROW);
    assign row_idx          = w_row_cnt;
    // Pulse on the row-accept cycle only; the state leaves REQ_ROW on the next edge.
    assign eng_pixel_ready  = (r_state == REQ_ROW) && row_valid;
    assign eng_weight_ready = r_wt_rdy;
    // Decoded from state only, so it never follows out_ready combinationally.
    assign out_valid        = (r_state == EMIT);
    assign out_data         = r_out_data;
    assign out_row          = r_out_row;
    assign out_och          = r_out_och;

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Directed bench: job table plus hand sequences for reset-mid-job and start-held-high.
// Latency: engine model returns kernel done 9 cycles after each eng_pixel_ready.
// Backpressure: out_ready is stalled on a chosen row to exercise EMIT hold.
module tb_conv_row_scheduler;
    import conv_sched_pkg::*;

    localparam int PIX = 3;
    localparam int RES = 8;
    localparam int CW  = 8;
    localparam int DW  = PIX * RES;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] cfg_rows;
    logic [CW-1:0] cfg_och;
    logic          busy;
    logic          done;
    logic          err;
    logic          wt_req;
    logic [CW-1:0] wt_och;
    logic          wt_valid;
    logic          row_req;
    logic [CW-1:0] row_idx;
    logic          row_valid;
    logic          eng_pixel_ready;
    logic          eng_weight_ready;
    logic          eng_kernel_done;
    logic [DW-1:0] eng_acc;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_row;
    logic [CW-1:0] out_och;

    always #5 clk = ~clk;

    conv_row_scheduler #(.KX(3), .PIX(PIX), .RES(RES), .CW(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .cfg_rows         (cfg_rows),
        .cfg_och          (cfg_och),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .wt_req           (wt_req),
        .wt_och           (wt_och),
        .wt_valid         (wt_valid),
        .row_req          (row_req),
        .row_idx          (row_idx),
        .row_valid        (row_valid),
        .eng_pixel_ready  (eng_pixel_ready),
        .eng_weight_ready (eng_weight_ready),
        .eng_kernel_done  (eng_kernel_done),
        .eng_acc          (eng_acc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_row          (out_row),
        .out_och          (out_och)
    );

    typedef struct {
        int rows;
        int och;
        int stall_row;
        int stall_len;
        bit inj;
        bit exp_err;
    } job_t;

    typedef struct {
        logic [CW-1:0] row;
        logic [CW-1:0] och;
        logic [DW-1:0] data;
    } res_t;

    int   n_checks = 0;
    int   n_errors = 0;
    res_t res_q[$];
    job_t jobs[5];

    // Engine model / monitor state.
    bit            prev_wt, prev_row, inj_kd;
    int            kd_cnt, stall_row, stall_left, stall_seen;
    logic [DW-1:0] stall_snap;
    logic [CW-1:0] cur_row, cur_och, last_pix_row;
    int            tot_wt, tot_row, tot_ov, tot_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_done"}, 64'(done), 0);
        check({tag, "_err"}, 64'(err), 0);
        check({tag, "_wt_req"}, 64'(wt_req), 0);
        check({tag, "_row_req"}, 64'(row_req), 0);
        check({tag, "_pix_rdy"}, 64'(eng_pixel_ready), 0);
        check({tag, "_wt_rdy"}, 64'(eng_weight_ready), 0);
        check({tag, "_out_valid"}, 64'(out_valid), 0);
        check({tag, "_out_data"}, 64'(out_data), 0);
        check({tag, "_out_row"}, 64'(out_row), 0);
        check({tag, "_out_och"}, 64'(out_och), 0);
    endtask

    task automatic wait_done(output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        while ((cyc < 3000) && !got) begin
            @(posedge clk);
            cyc++;
            #3;
            if (done) got = 1'b1;
        end
        check("done_within_budget", 64'(got), 1);
    endtask

    task automatic run_job(input job_t j);
        int w0, r0, v0, d0, cyc;
        bit got;
        logic [DW-1:0] e;
        res_q.delete();
        w0 = tot_wt; r0 = tot_row; v0 = tot_ov; d0 = tot_done;
        stall_row  = j.stall_row;
        stall_left = j.stall_len;
        stall_seen = 0;
        inj_kd     = j.inj;
        @(negedge clk);
        cfg_rows = CW'(j.rows);
        cfg_och  = CW'(j.och);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        cfg_rows = 8'd7;   // must not affect the running job
        cfg_och  = 8'd9;
        wait_done(cyc, got);
        check("busy_at_done", 64'(busy), 0);
        if ((j.rows == 0) || (j.och == 0)) begin
            check("empty_done_latency", 64'(cyc), 1);
            check("empty_no_wt_req", 64'(tot_wt - w0), 0);
            check("empty_no_row_req", 64'(tot_row - r0), 0);
            check("empty_no_out_valid", 64'(tot_ov - v0), 0);
        end
        check("result_count", 64'(res_q.size()), 64'(j.rows * j.och));
        for (int o = 0; o < j.och; o++) begin
            for (int r = 0; r < j.rows; r++) begin
                int k;
                k = o * j.rows + r;
                if (k < res_q.size()) begin
                    e = {8'(r), 8'(o), 8'hC3};
                    check("res_och", 64'(res_q[k].och), 64'(o));
                    check("res_row", 64'(res_q[k].row), 64'(r));
                    check("res_data", 64'(res_q[k].data), 64'(e));
                end
            end
        end
        @(posedge clk);
        #3;
        check("done_pulse_count", 64'(tot_done - d0), 1);
        check("err_state", 64'(err), 64'(j.exp_err));
        if (j.stall_len > 0) check("stall_cycles", 64'(stall_seen), 64'(j.stall_len));
    endtask

    initial begin
        int  cyc, d0, v0, w0, r0, n;
        bit  got;
        job_t j1;
        rst = 1'b1; start = 1'b0; cfg_rows = '0; cfg_och = '0;
        wt_valid = 1'b0; row_valid = 1'b0; eng_kernel_done = 1'b0; eng_acc = '0;
        out_ready = 1'b1;
        prev_wt = 0; prev_row = 0; inj_kd = 0; kd_cnt = 0;
        stall_row = -1; stall_left = 0; stall_seen = 0; stall_snap = '0;
        cur_row = '0; cur_och = '0; last_pix_row = 8'hFF;
        tot_wt = 0; tot_row = 0; tot_ov = 0; tot_done = 0;

        fork
            forever begin
                @(posedge clk);
                #1;
                if (rst) begin
                    prev_wt = 0; prev_row = 0; kd_cnt = 0;
                    wt_valid = 1'b0; row_valid = 1'b0; eng_kernel_done = 1'b0;
                    out_ready = 1'b1;
                end else begin
                    // Requests are granted on their second cycle.
                    wt_valid  = wt_req && prev_wt;
                    prev_wt   = wt_req && !wt_valid;
                    row_valid = row_req && prev_row;
                    prev_row  = row_req && !row_valid;
                    eng_kernel_done = 1'b0;
                    if (kd_cnt > 0) begin
                        kd_cnt--;
                        if (kd_cnt == 0) begin
                            eng_kernel_done = 1'b1;
                            eng_acc = {cur_row, cur_och, 8'hC3};
                        end
                    end
                    if (inj_kd && wt_req) begin
                        eng_kernel_done = 1'b1;
                        inj_kd = 1'b0;
                    end
                    if (out_valid && (stall_left > 0) && (out_row == stall_row)) begin
                        out_ready = 1'b0;
                        stall_left--;
                        stall_seen++;
                        if (stall_seen == 1) stall_snap = out_data;
                        else check("stall_data_hold", 64'(out_data), 64'(stall_snap));
                        check("stall_no_row_req", 64'(row_req), 0);
                    end else begin
                        out_ready = 1'b1;
                    end
                    #1;
                    if (eng_pixel_ready) begin
                        kd_cnt       = 9;
                        cur_row      = row_idx;
                        cur_och      = wt_och;
                        last_pix_row = row_idx;
                        check("wt_ready_at_pixel", 64'(eng_weight_ready), 1);
                    end
                    if (wt_req) tot_wt++;
                    if (row_req) tot_row++;
                    if (out_valid) tot_ov++;
                    if (done) tot_done++;
                    if (out_valid && out_ready) res_q.push_back('{out_row, out_och, out_data});
                end
            end
        join_none

        // Reset state.
        repeat (3) @(posedge clk);
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        jobs[0] = '{2, 2, -1, 0, 1'b0, 1'b0};
        jobs[1] = '{3, 1,  1, 5, 1'b0, 1'b0};
        jobs[2] = '{0, 4, -1, 0, 1'b0, 1'b0};
        jobs[3] = '{1, 3, -1, 0, 1'b0, 1'b0};
        jobs[4] = '{2, 1, -1, 0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) run_job(jobs[i]);

        // Reset during RUN of row 1, then a clean 1x1 job.
        last_pix_row = 8'hFF;
        @(negedge clk);
        cfg_rows = 8'd3; cfg_och = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while ((last_pix_row != 8'd1) && (n < 500)) begin
            @(negedge clk);
            n++;
        end
        check("reached_row1_run", 64'(last_pix_row), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        w0 = tot_wt; r0 = tot_row; v0 = tot_ov;
        @(posedge clk);
        #3;
        check("idle_after_rst_release", 64'(busy), 0);
        repeat (12) @(posedge clk);
        #3;
        check("no_req_after_rst", 64'((tot_wt - w0) + (tot_row - r0) + (tot_ov - v0)), 0);
        j1 = '{1, 1, -1, 0, 1'b0, 1'b0};
        run_job(j1);

        // Start held high across a 1x1 job.
        res_q.delete();
        d0 = tot_done;
        @(negedge clk);
        cfg_rows = 8'd1; cfg_och = 8'd1; start = 1'b1;
        wait_done(cyc, got);
        check("held_first_done_count", 64'(tot_done - d0), 1);
        check("held_first_results", 64'(res_q.size()), 1);
        check("held_idle_at_done", 64'(busy), 0);
        @(posedge clk);
        #3;
        check("held_restart_busy", 64'(busy), 1);
        check("held_restart_wt_req", 64'(wt_req), 1);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, got);
        check("held_total_results", 64'(res_q.size()), 2);
        if (res_q.size() == 2) begin
            check("held_second_row", 64'(res_q[1].row), 0);
            check("held_second_och", 64'(res_q[1].och), 0);
        end
        check("held_total_done", 64'(tot_done - d0), 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
